// File: rtl/bcd_updown_counter.sv
// bcd_updown_counter: modulo 0..MAX_COUNT up/down counter with load, wrap/saturate, binary and cascaded-BCD outputs
module bcd_updown_counter #(
  parameter int DIGITS = 2,
  parameter int MAX_COUNT = 99,
  parameter int WIDTH = 7
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  en,
  input  logic                  up,
  input  logic                  load,
  input  logic [WIDTH-1:0]      load_val,
  input  logic                  sat,
  output logic [WIDTH-1:0]      count,
  output logic [4*DIGITS-1:0]   bcd,
  output logic                  tc,
  output logic                  at_max,
  output logic                  at_min
);
  function automatic logic [4*DIGITS-1:0] to_bcd(input logic [WIDTH-1:0] v);
    logic [4*DIGITS-1:0] b;
    b = '0;
    for (int i = WIDTH - 1; i >= 0; i--) begin
      for (int d = 0; d < DIGITS; d++) b[4*d+:4] = b[4*d+:4] >= 4'd5 ? b[4*d+:4] + 4'd3 : b[4*d+:4];
      b = {b[4*DIGITS-2:0], v[i]};
    end
    return b;
  endfunction
  localparam logic [WIDTH-1:0] MAXV = WIDTH'(MAX_COUNT);
  localparam logic [4*DIGITS-1:0] MAXB = to_bcd(MAXV);
  logic [WIDTH-1:0] lv;
  logic [4*DIGITS-1:0] bcd_up, bcd_dn;
  assign at_max = count == MAXV;
  assign at_min = count == '0;
  assign lv = load_val > MAXV ? MAXV : load_val;
  // Decade chain: a digit steps only when every lower digit is about to roll over
  always_comb begin
    logic c, b;
    bcd_up = bcd;
    bcd_dn = bcd;
    c = 1'b1;
    b = 1'b1;
    for (int i = 0; i < DIGITS; i++) begin
      bcd_up[4*i+:4] = c ? (bcd[4*i+:4] == 4'd9 ? 4'd0 : bcd[4*i+:4] + 4'd1) : bcd[4*i+:4];
      bcd_dn[4*i+:4] = b ? (bcd[4*i+:4] == 4'd0 ? 4'd9 : bcd[4*i+:4] - 4'd1) : bcd[4*i+:4];
      c = c & (bcd[4*i+:4] == 4'd9);
      b = b & (bcd[4*i+:4] == 4'd0);
    end
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      count <= '0;
      bcd <= '0;
      tc <= 1'b0;
    end else if (load) begin
      count <= lv;
      bcd <= to_bcd(lv);
      tc <= 1'b0;
    end else if (en && up) begin
      tc <= at_max;
      count <= at_max ? (sat ? count : '0) : count + WIDTH'(1);
      bcd <= at_max ? (sat ? bcd : '0) : bcd_up;
    end else if (en) begin
      tc <= at_min;
      count <= at_min ? (sat ? count : MAXV) : count - WIDTH'(1);
      bcd <= at_min ? (sat ? bcd : MAXB) : bcd_dn;
    end else begin
      tc <= 1'b0;
    end
  end
endmodule
